// File: rtl/d_reg_pkg.sv
// d_reg_pkg: shared defaults and data word type for the d_reg register slice.
package d_reg_pkg;
    localparam int D_REG_WIDTH_DEFAULT = 4;
    localparam logic [63:0] D_REG_RESET_DEFAULT = '0;
    typedef logic [D_REG_WIDTH_DEFAULT-1:0] d_word_t;
endpackage

// File: rtl/d_reg_bit.sv
// d_reg_bit: one-bit load-enabled flop with complement output; bus cell when D_REG_BUS_EN is defined.
module d_reg_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Load,
    input  logic D,
`ifdef D_REG_BUS_EN
    input  logic OutEn,
    output logic Bus,
`endif
    output logic Q,
    output logic Qn
);
    logic q_d, q_q;

    always_comb q_d = Load ? D : q_q;

    always_ff @(posedge Clk) begin
        q_q <= Rst ? RESET_BIT : q_d;
    end

    assign Q  = q_q;
    assign Qn = ~q_q;
`ifdef D_REG_BUS_EN
    assign Bus = OutEn ? ~q_q : 1'bz;
`endif
endmodule

// File: rtl/d_reg.sv
// d_reg: WIDTH-bit load-enabled register with Q/Qn; inverted tri-state bus output when D_REG_BUS_EN is defined.
module d_reg
    import d_reg_pkg::*;
#(
    parameter int WIDTH = D_REG_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = D_REG_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
`ifdef D_REG_BUS_EN
    input  logic             OutEn,
    output logic [WIDTH-1:0] Bus,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_reg_bit #(.RESET_BIT(RESET_VALUE[i])) u_bit (
            .Clk  (Clk),
            .Rst  (Rst),
            .Load (Load),
            .D    (D[i]),
`ifdef D_REG_BUS_EN
            .OutEn(OutEn),
            .Bus  (Bus[i]),
`endif
            .Q    (Q[i]),
            .Qn   (Qn[i])
        );
    end
endmodule

// File: tb/tb_d_reg.sv
// tb_d_reg: directed checks of d_reg at default width and at WIDTH=8, RESET_VALUE=8'hA5; bus checks under D_REG_BUS_EN.
module tb_d_reg;
    logic       clk = 1'b0;
    logic       rst, load, oe;
    logic [3:0] d4, q4, qn4, bus4;
    logic [7:0] d8, q8, qn8, bus8;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    d_reg u_dut4 (
        .Clk  (clk),
        .Rst  (rst),
        .Load (load),
        .D    (d4),
`ifdef D_REG_BUS_EN
        .OutEn(oe),
        .Bus  (bus4),
`endif
        .Q    (q4),
        .Qn   (qn4)
    );

    d_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
        .Clk  (clk),
        .Rst  (rst),
        .Load (load),
        .D    (d8),
`ifdef D_REG_BUS_EN
        .OutEn(oe),
        .Bus  (bus8),
`endif
        .Q    (q8),
        .Qn   (qn8)
    );

`ifndef D_REG_BUS_EN
    assign bus4 = 4'h0;
    assign bus8 = 8'h0;
`endif

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; oe = 1'b0; d4 = 4'hA; d8 = 8'hFF;
        tick;
        check("rst_q", {4'h0, q4}, 8'h00);
        check("rst_qn", {4'h0, qn4}, 8'h0F);
        check("rst_q8", q8, 8'hA5);
        check("rst_qn8", qn8, 8'h5A);

        rst = 1'b0; load = 1'b1; d4 = 4'h5; d8 = 8'h3C;
        check("pre_edge_q", {4'h0, q4}, 8'h00);
        tick;
        check("load_q", {4'h0, q4}, 8'h05);
        check("load_qn", {4'h0, qn4}, 8'h0A);
        check("load_q8", q8, 8'h3C);
        check("load_qn8", qn8, 8'hC3);

        load = 1'b0;
        d4 = 4'h3; tick; check("hold1", {4'h0, q4}, 8'h05);
        d4 = 4'hC; tick; check("hold2", {4'h0, q4}, 8'h05);
        d4 = 4'h3; tick; check("hold3", {4'h0, q4}, 8'h05);
        check("hold_q8", q8, 8'h3C);

        d4 = 4'hF; load = 1'b1; rst = 1'b1;
        #2;
        check("mid_cycle_q", {4'h0, q4}, 8'h05);
        check("mid_cycle_qn", {4'h0, qn4}, 8'h0A);
        load = 1'b0; rst = 1'b0;
        tick;
        check("mid_cycle_edge", {4'h0, q4}, 8'h05);

        rst = 1'b1; load = 1'b1; d4 = 4'h9; d8 = 8'h00;
        tick;
        check("rst_load_q", {4'h0, q4}, 8'h00);
        check("rst_load_qn", {4'h0, qn4}, 8'h0F);
        check("rst_load_q8", q8, 8'hA5);

        rst = 1'b0; load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d4 = 4'(1 << i);
            d8 = 8'(8'h80 >> i);
            tick;
            check("walk_q", {4'h0, q4}, 8'(1 << i));
            check("walk_q8", q8, 8'(8'h80 >> i));
        end
        d4 = 4'hF; tick; check("all_ones", {4'h0, q4}, 8'h0F); check("all_ones_qn", {4'h0, qn4}, 8'h00);
        d4 = 4'h0; tick; check("all_zero", {4'h0, q4}, 8'h00); check("all_zero_qn", {4'h0, qn4}, 8'h0F);

        d4 = 4'h6; d8 = 8'h6C; tick;
        load = 1'b0; rst = 1'b1; tick;
        check("rst_only_q", {4'h0, q4}, 8'h00);
        check("rst_only_q8", q8, 8'hA5);
        rst = 1'b0;

`ifdef D_REG_BUS_EN
        load = 1'b1; d4 = 4'h6; d8 = 8'h6C; tick; load = 1'b0;
        oe = 1'b1; #1;
        check("bus_on", {4'h0, bus4}, 8'h09);
        check("bus_on8", bus8, 8'h93);
        oe = 1'b0; #1;
        check("bus_off", {4'h0, bus4}, {4'h0, 4'hz});
        check("bus_off8", bus8, 8'hzz);
        check("bus_off_q", {4'h0, q4}, 8'h06);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
